// File: rtl/delay_window_checker.sv
// delay_window_checker: run-time checker for "a |-> ##[MIN_DLY:MAX_DLY] b" over CHANNELS independent channels
module delay_window_checker #(
   parameter int CHANNELS = 1,
   parameter int MIN_DLY  = 1,
   parameter int MAX_DLY  = 2,
   parameter int MODE     = 0,
   parameter int CNT_W    = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] a,
   input  logic [CHANNELS-1:0] b,
   output logic [CHANNELS-1:0] fail,
   output logic [CHANNELS-1:0] pending,
   output logic [CNT_W-1:0]    fail_cnt,
   output logic                fail_sticky
);
   localparam int SW = CNT_W + 6;
   if (MIN_DLY < 0 || MIN_DLY > MAX_DLY || MAX_DLY > 31 || CHANNELS < 1 || CHANNELS > 32) begin : g_bad_params
      $error("delay_window_checker: illegal parameter combination");
   end
   logic [CHANNELS-1:0] expire, pend_nxt;
   logic [SW-1:0]       n_fail, sum;
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [MAX_DLY:0] cur, upd;
      logic             hit;
      // scanning from the oldest age down lets MODE 1 retire only the oldest in-window obligation
      always_comb begin
         upd = cur;
         hit = 1'b0;
         for (int k = MAX_DLY; k >= MIN_DLY; k--) begin
            if (b[c] && upd[k] && (MODE == 0 || !hit)) begin
               upd[k] = 1'b0;
               hit    = 1'b1;
            end
         end
      end
      assign expire[c] = upd[MAX_DLY];
      if (MAX_DLY > 0) begin : g_pend
         logic [MAX_DLY-1:0] pend_q;
         assign cur         = {pend_q, a[c]};
         assign pend_nxt[c] = |upd[MAX_DLY-1:0];
         always_ff @(posedge clock) begin
            if (reset) pend_q <= '0;
            else       pend_q <= upd[MAX_DLY-1:0];
         end
      end else begin : g_no_pend
         assign cur         = a[c];
         assign pend_nxt[c] = 1'b0;
      end
   end
   always_comb begin
      n_fail = '0;
      for (int i = 0; i < CHANNELS; i++) n_fail = n_fail + SW'(expire[i]);
      sum = SW'(fail_cnt) + n_fail;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         fail        <= '0;
         pending     <= '0;
         fail_cnt    <= '0;
         fail_sticky <= 1'b0;
      end else begin
         fail        <= expire;
         pending     <= pend_nxt;
         fail_cnt    <= sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
         fail_sticky <= fail_sticky | (|expire);
      end
   end
endmodule
